// File: rtl/apb_guard_pkg.sv
// Shared types and constants for the APB timeout guard.
// Holds the FSM state encoding, default error read data and event counter width.
package apb_guard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_guard_state_e;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;
  localparam int          EVENT_CNT_W       = 8;

endpackage

// File: rtl/apb_guard_timer.sv
// Downstream wait-phase counter for the APB guard.
// expired flags the cycle in which one more wait would reach the programmed limit.
module apb_guard_timer #(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 count_en,
  input  logic                 clear,
  input  logic [TIMEOUT_W-1:0] limit,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] r_count;
  logic [TIMEOUT_W:0]   w_count_inc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (count_en) begin
      r_count <= r_count + TIMEOUT_W'(1);
    end
  end

  // Extra bit keeps count+1 from wrapping onto a small limit.
  assign w_count_inc = {1'b0, r_count} + (TIMEOUT_W + 1)'(1);
  assign expired     = (limit != '0) && (w_count_inc == {1'b0, limit});

endmodule

// File: rtl/apb_timeout_guard.sv
// APB guard between an interconnect target port and a subsystem slave.
// Re-times each transfer, isolates a disabled subsystem and aborts over-long wait phases.
module apb_timeout_guard
  import apb_guard_pkg::*;
#(
  parameter int                APB_AW    = 32,
  parameter int                APB_DW    = 32,
  parameter int                TIMEOUT_W = 8,
  parameter logic [APB_DW-1:0] ERR_RDATA = APB_DW'(ERR_RDATA_DEFAULT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [APB_AW-1:0]      S_APB_PADDR,
  input  logic [APB_DW-1:0]      S_APB_PWDATA,
  input  logic [APB_DW/8-1:0]    S_APB_PSTRB,
  input  logic                   S_APB_PWRITE,
  input  logic                   S_APB_PSEL,
  input  logic                   S_APB_PENABLE,
  output logic [APB_DW-1:0]      S_APB_PRDATA,
  output logic                   S_APB_PREADY,
  output logic                   S_APB_PSLVERR,
  output logic [APB_AW-1:0]      M_APB_PADDR,
  output logic [APB_DW-1:0]      M_APB_PWDATA,
  output logic [APB_DW/8-1:0]    M_APB_PSTRB,
  output logic                   M_APB_PWRITE,
  output logic                   M_APB_PSEL,
  output logic                   M_APB_PENABLE,
  input  logic [APB_DW-1:0]      M_APB_PRDATA,
  input  logic                   M_APB_PREADY,
  input  logic                   M_APB_PSLVERR,
  input  logic                   ss_enable,
  input  logic [TIMEOUT_W-1:0]   timeout_limit,
  input  logic                   timeout_clr,
  output logic                   timeout_flag,
  output logic [EVENT_CNT_W-1:0] event_cnt
);

  apb_guard_state_e r_state;
  apb_guard_state_e w_state_nxt;

  logic                   w_start;
  logic                   w_load;
  logic                   w_abort;
  logic                   w_fwd_nxt;
  logic                   w_expired;
  logic                   w_count_en;
  logic                   w_timer_clr;
  logic [APB_DW-1:0]      w_s_prdata_nxt;
  logic                   w_s_pslverr_nxt;

  logic [APB_DW-1:0]      r_s_prdata;
  logic                   r_s_pready;
  logic                   r_s_pslverr;
  logic [APB_AW-1:0]      r_m_paddr;
  logic [APB_DW-1:0]      r_m_pwdata;
  logic [APB_DW/8-1:0]    r_m_pstrb;
  logic                   r_m_pwrite;
  logic                   r_m_psel;
  logic                   r_m_penable;
  logic                   r_timeout_flag;
  logic [EVENT_CNT_W-1:0] r_event_cnt;

  assign w_start     = S_APB_PSEL && !S_APB_PENABLE;
  assign w_count_en  = (r_state == ACCESS) && !M_APB_PREADY;
  assign w_timer_clr = (r_state != ACCESS);

  apb_guard_timer #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (w_count_en),
    .clear    (w_timer_clr),
    .limit    (timeout_limit),
    .expired  (w_expired)
  );

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_load          = 1'b0;
    w_abort         = 1'b0;
    w_s_prdata_nxt  = '0;
    w_s_pslverr_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          if (ss_enable) begin
            w_state_nxt = SETUP;
            w_load      = 1'b1;
          end else begin
            w_state_nxt     = RESP;
            w_s_prdata_nxt  = ERR_RDATA;
            w_s_pslverr_nxt = 1'b1;
          end
        end
      end
      SETUP: w_state_nxt = ACCESS;
      ACCESS: begin
        // A ready slave always wins over an expiring limit in the same cycle.
        if (M_APB_PREADY) begin
          w_state_nxt     = RESP;
          w_s_prdata_nxt  = M_APB_PRDATA;
          w_s_pslverr_nxt = M_APB_PSLVERR;
        end else if (w_expired) begin
          w_state_nxt     = RESP;
          w_abort         = 1'b1;
          w_s_prdata_nxt  = ERR_RDATA;
          w_s_pslverr_nxt = 1'b1;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_fwd_nxt = (w_state_nxt == SETUP) || (w_state_nxt == ACCESS);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_s_pready  <= 1'b0;
      r_s_prdata  <= '0;
      r_s_pslverr <= 1'b0;
      r_m_psel    <= 1'b0;
      r_m_penable <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_s_pready  <= (w_state_nxt == RESP);
      r_s_prdata  <= w_s_prdata_nxt;
      r_s_pslverr <= w_s_pslverr_nxt;
      r_m_psel    <= w_fwd_nxt;
      r_m_penable <= (w_state_nxt == ACCESS);
    end
  end

  // The downstream request registers double as the capture of the upstream setup.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_paddr  <= '0;
      r_m_pwdata <= '0;
      r_m_pstrb  <= '0;
      r_m_pwrite <= 1'b0;
    end else if (w_load) begin
      r_m_paddr  <= S_APB_PADDR;
      r_m_pwdata <= S_APB_PWDATA;
      r_m_pstrb  <= S_APB_PSTRB;
      r_m_pwrite <= S_APB_PWRITE;
    end else if (!w_fwd_nxt) begin
      r_m_paddr  <= '0;
      r_m_pwdata <= '0;
      r_m_pstrb  <= '0;
      r_m_pwrite <= 1'b0;
    end
  end

  // An abort takes priority over a same-cycle clear, leaving a count of one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeout_flag <= 1'b0;
      r_event_cnt    <= '0;
    end else if (w_abort) begin
      r_timeout_flag <= 1'b1;
      if (timeout_clr) begin
        r_event_cnt <= EVENT_CNT_W'(1);
      end else if (r_event_cnt != '1) begin
        r_event_cnt <= r_event_cnt + EVENT_CNT_W'(1);
      end
    end else if (timeout_clr) begin
      r_timeout_flag <= 1'b0;
      r_event_cnt    <= '0;
    end
  end

  assign S_APB_PRDATA  = r_s_prdata;
  assign S_APB_PREADY  = r_s_pready;
  assign S_APB_PSLVERR = r_s_pslverr;
  assign M_APB_PADDR   = r_m_paddr;
  assign M_APB_PWDATA  = r_m_pwdata;
  assign M_APB_PSTRB   = r_m_pstrb;
  assign M_APB_PWRITE  = r_m_pwrite;
  assign M_APB_PSEL    = r_m_psel;
  assign M_APB_PENABLE = r_m_penable;
  assign timeout_flag  = r_timeout_flag;
  assign event_cnt     = r_event_cnt;

endmodule
